// File: rtl/cam_pattern_gen_if.sv
// Signal bundle between the synthetic DVP camera source and its consumer.
// The generator owns the master side; the capture path or bench uses slave.
interface cam_pattern_gen_if;
  logic        enable;
  logic [1:0]  mode;
  logic        byte_swap;
  logic [7:0]  cmos_data;
  logic        cmos_href;
  logic        cmos_vsyn;
  logic [15:0] frame_cnt;
  logic        frame_done;

  modport master (
    input  enable, mode, byte_swap,
    output cmos_data, cmos_href, cmos_vsyn, frame_cnt, frame_done
  );

  modport slave (
    output enable, mode, byte_swap,
    input  cmos_data, cmos_href, cmos_vsyn, frame_cnt, frame_done
  );
endinterface

// File: rtl/cam_pattern_gen.sv
// Byte-serial RGB565 DVP camera source with per-frame pattern/byte-order latch,
// clean start/stop at frame boundaries and a completed-frame counter.
module cam_pattern_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 100,
  parameter int V_SYNC    = 1000,
  parameter int V_BACK    = 1000,
  parameter int F_GAP     = 2000,
  parameter int CHK_SHIFT = 3
) (
  input  logic               cmos_pclk,
  input  logic               rst_n,
  cam_pattern_gen_if.master  bus
);

  localparam int BAR_W = H_ACTIVE / 16;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_HBLANK, S_ACTIVE, S_FGAP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, r_row, r_seq, r_frame_cnt;
  logic [1:0]  r_mode;
  logic        r_swap;
  logic [7:0]  r_data;
  logic        r_href, r_vsyn, r_done;

  logic        w_last, w_start;
  logic [15:0] w_p, w_pval;
  logic [7:0]  w_data;
  logic        w_href, w_vsyn, w_done;

  // r_cnt counts cycles spent in the current state; w_last marks its final one.
  always_comb begin
    w_last = 1'b0;
    unique case (r_state)
      S_VSYNC:  w_last = (r_cnt == 16'(V_SYNC - 1));
      S_VBACK:  w_last = (r_cnt == 16'(V_BACK - 1));
      S_HBLANK: w_last = (r_cnt == 16'(H_BLANK - 1));
      S_ACTIVE: w_last = (r_cnt == 16'(2 * H_ACTIVE - 1));
      S_FGAP:   w_last = (r_cnt == 16'(F_GAP - 1));
      default:  w_last = 1'b0;
    endcase
  end

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.enable) w_state_nxt = S_VSYNC;
      S_VSYNC:  if (w_last) w_state_nxt = S_VBACK;
      S_VBACK:  if (w_last) w_state_nxt = S_HBLANK;
      S_HBLANK: if (w_last) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_last) w_state_nxt = (r_row == 16'(V_ACTIVE - 1)) ? S_FGAP : S_HBLANK;
      S_FGAP:   if (w_last) w_state_nxt = bus.enable ? S_VSYNC : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);

  always_comb begin
    w_p    = r_cnt >> 1;
    w_pval = 16'h0000;
    unique case (r_mode)
      2'd0:    w_pval = r_seq;
      2'd1:    w_pval = 16'h8000 >> (w_p / 16'(BAR_W));
      2'd2:    w_pval = {16{w_p[CHK_SHIFT] ^ r_row[CHK_SHIFT]}};
      default: w_pval = r_row;
    endcase
    w_vsyn = (r_state == S_VSYNC);
    w_href = (r_state == S_ACTIVE);
    w_done = (r_state == S_FGAP) && w_last;
    w_data = 8'h00;
    // Even byte index is the pixel's first byte; byte_swap flips which half goes first.
    if (w_href) w_data = (r_cnt[0] ^ r_swap) ? w_pval[7:0] : w_pval[15:8];
  end

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_row       <= '0;
      r_seq       <= '0;
      r_mode      <= '0;
      r_swap      <= 1'b0;
      r_frame_cnt <= '0;
      r_data      <= '0;
      r_href      <= 1'b0;
      r_vsyn      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_state_nxt != r_state) r_cnt <= '0;
      else                                             r_cnt <= r_cnt + 16'd1;

      if (w_start) begin
        r_mode <= bus.mode;
        r_swap <= bus.byte_swap;
        r_row  <= '0;
        r_seq  <= '0;
      end else begin
        if (r_state == S_ACTIVE && w_last && w_state_nxt == S_HBLANK) r_row <= r_row + 16'd1;
        if (r_state == S_ACTIVE && r_cnt[0]) r_seq <= r_seq + 16'd1;
      end

      if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;

      r_data <= w_data;
      r_href <= w_href;
      r_vsyn <= w_vsyn;
      r_done <= w_done;
    end
  end

  assign bus.cmos_data  = r_data;
  assign bus.cmos_href  = r_href;
  assign bus.cmos_vsyn  = r_vsyn;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: frame-phase reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control traffic.
module tb_cam_pattern_gen;

  localparam int HA = 16, VA = 4, HB = 4, VS = 8, VB = 4, FG = 4, CS = 1;
  localparam int LINE  = HB + 2 * HA;
  localparam int FRAME = VS + VB + VA * LINE + FG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_pattern_gen_if bus();

  cam_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_SYNC(VS),
    .V_BACK(VB), .F_GAP(FG), .CHK_SHIFT(CS)
  ) dut (
    .cmos_pclk(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          m_ph = -1;
  logic [1:0]  m_mode = 2'd0;
  logic        m_swap = 1'b0;
  logic [15:0] m_fcnt = 16'h0000;

  logic [7:0] o_data [0:FRAME];
  int o_vs, o_vs_first, o_href, o_burst, o_first_href, o_done_edge, o_done_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pix_val(input logic [1:0] md, input int p, input int l);
    case (md)
      2'd0:    return 16'(l * HA + p);
      2'd1:    return 16'h8000 >> (p / (HA / 16));
      2'd2:    return ((((p >> CS) ^ (l >> CS)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return 16'(l);
    endcase
  endfunction

  // Reference: m_ph is the frame phase (0..FRAME-1) the generator sits in before
  // an edge; the registered outputs after that edge describe that phase.
  task automatic run_model();
    logic       e_vs, e_href, e_done;
    logic [7:0] e_data;
    logic [15:0] e_fc, pv;
    int rel, l, off, b, p;
    forever begin
      @(posedge clk);
      e_vs = 1'b0; e_href = 1'b0; e_done = 1'b0; e_data = 8'h00;
      if (!rst_n) begin
        m_ph = -1;
        m_fcnt = 16'h0000;
      end else begin
        if (m_ph >= 0 && m_ph < VS) e_vs = 1'b1;
        rel = m_ph - VS - VB;
        if (rel >= 0 && rel < VA * LINE) begin
          l = rel / LINE;
          off = rel % LINE;
          if (off >= HB) begin
            b = off - HB;
            p = b / 2;
            pv = pix_val(m_mode, p, l);
            e_href = 1'b1;
            e_data = (((b % 2) == 0) ^ m_swap) ? pv[15:8] : pv[7:0];
          end
        end
        if (m_ph == FRAME - 1) begin
          e_done = 1'b1;
          m_fcnt = m_fcnt + 16'd1;
        end
        if (m_ph < 0 || m_ph == FRAME - 1) begin
          if (bus.enable) begin
            m_ph = 0;
            m_mode = bus.mode;
            m_swap = bus.byte_swap;
          end else begin
            m_ph = -1;
          end
        end else begin
          m_ph++;
        end
      end
      e_fc = m_fcnt;
      #1;
      chk("vsyn", 32'(bus.cmos_vsyn), 32'(e_vs));
      chk("href", 32'(bus.cmos_href), 32'(e_href));
      chk("data", 32'(bus.cmos_data), 32'(e_data));
      chk("frame_done", 32'(bus.frame_done), 32'(e_done));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(e_fc));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] md, input logic sw, input logic hold);
    @(negedge clk);
    bus.mode = md;
    bus.byte_swap = sw;
    bus.enable = 1'b1;
    step();
    if (!hold) bus.enable = 1'b0;
  endtask

  // Records one frame's worth of outputs; edge i is the i-th edge after the start edge.
  task automatic observe_frame(input int chg_at, input logic [1:0] chg_mode, input int en_off_at);
    logic prev_href;
    prev_href = 1'b0;
    o_vs = 0; o_vs_first = -1; o_href = 0; o_burst = 0;
    o_first_href = -1; o_done_edge = -1; o_done_n = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step();
      o_data[i] = bus.cmos_data;
      if (bus.cmos_vsyn) begin
        o_vs++;
        if (o_vs_first < 0) o_vs_first = i;
      end
      if (bus.cmos_href) begin
        o_href++;
        if (!prev_href) o_burst++;
        if (o_first_href < 0) o_first_href = i;
      end
      prev_href = bus.cmos_href;
      if (bus.frame_done) begin
        o_done_n++;
        o_done_edge = i;
      end
      if (i == chg_at) bus.mode = chg_mode;
      if (i == en_off_at) bus.enable = 1'b0;
    end
  endtask

  task automatic chk_pair(input string name, input int e, input logic [7:0] b0, input logic [7:0] b1);
    chk({name, "_b0"}, 32'(o_data[e]), 32'(b0));
    chk({name, "_b1"}, 32'(o_data[e + 1]), 32'(b1));
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.mode = 2'd0;
    bus.byte_swap = 1'b0;
    fork
      run_model();
    join_none

    // Reset and idle
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_vsyn", 32'(bus.cmos_vsyn), 32'd0);
    chk("idle_href", 32'(bus.cmos_href), 32'd0);
    chk("idle_data", 32'(bus.cmos_data), 32'd0);
    chk("idle_fcnt", 32'(bus.frame_cnt), 32'd0);

    // Sequence frame, single-cycle enable pulse
    start_frame(2'd0, 1'b0, 1'b0);
    observe_frame(-1, 2'd0, -1);
    chk("f1_vs_first", 32'(o_vs_first), 32'd1);
    chk("f1_vs_len", 32'(o_vs), 32'd8);
    chk("f1_href_first", 32'(o_first_href), 32'd17);
    chk("f1_href_total", 32'(o_href), 32'd128);
    chk("f1_bursts", 32'(o_burst), 32'd4);
    chk_pair("f1_px0", 17, 8'h00, 8'h00);
    chk_pair("f1_px1", 19, 8'h00, 8'h01);
    chk_pair("f1_px15", 47, 8'h00, 8'h0F);
    chk_pair("f1_l1px0", 53, 8'h00, 8'h10);
    chk("f1_done_edge", 32'(o_done_edge), 32'd160);
    chk("f1_done_n", 32'(o_done_n), 32'd1);
    chk("f1_fcnt", 32'(bus.frame_cnt), 32'd1);
    repeat (10) step();
    chk("f1_back_idle", 32'(bus.cmos_vsyn), 32'd0);

    // Colour bars, swapped bytes
    start_frame(2'd1, 1'b1, 1'b0);
    observe_frame(-1, 2'd0, -1);
    chk_pair("bars_px0", 17, 8'h00, 8'h80);
    chk_pair("bars_px15", 47, 8'h01, 8'h00);

    // Checkerboard
    start_frame(2'd2, 1'b0, 1'b0);
    observe_frame(-1, 2'd0, -1);
    chk_pair("chk_r0p2", 21, 8'hFF, 8'hFF);
    chk_pair("chk_r2p2", 93, 8'h00, 8'h00);

    // Row ramp with mode change during row 1, enable held, then enable dropped mid-frame
    start_frame(2'd3, 1'b0, 1'b1);
    observe_frame(60, 2'd0, -1);
    chk_pair("ramp_r1", 53, 8'h00, 8'h01);
    chk_pair("ramp_r2", 89, 8'h00, 8'h02);
    chk("ramp_done_edge", 32'(o_done_edge), 32'd160);
    observe_frame(-1, 2'd0, 30);
    chk("b2b_vs_first", 32'(o_vs_first), 32'd1);
    chk_pair("b2b_px1", 19, 8'h00, 8'h01);
    chk("b2b_done_edge", 32'(o_done_edge), 32'd160);
    chk("b2b_fcnt", 32'(bus.frame_cnt), 32'd5);
    repeat (10) step();
    chk("b2b_stop_vsyn", 32'(bus.cmos_vsyn), 32'd0);

    // Reset in the middle of an active line
    start_frame(2'd0, 1'b0, 1'b0);
    repeat (30) step();
    chk("rst_pre_data", 32'(bus.cmos_data), 32'h06);
    @(negedge clk);
    rst_n = 1'b0;
    step();
    chk("rst_href", 32'(bus.cmos_href), 32'd0);
    chk("rst_data", 32'(bus.cmos_data), 32'd0);
    chk("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_after_href", 32'(bus.cmos_href), 32'd0);
    chk("rst_after_fcnt", 32'(bus.frame_cnt), 32'd0);

    // Counter wrap
    start_frame(2'd2, 1'b1, 1'b0);
    repeat (100) step();
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    m_fcnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    for (int i = 102; i <= FRAME; i++) step();
    chk("wrap_done", 32'(bus.frame_done), 32'd1);
    chk("wrap_fcnt", 32'(bus.frame_cnt), 32'd0);
    step();
    chk("wrap_done_clr", 32'(bus.frame_done), 32'd0);

    // Randomized control traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.byte_swap = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_pattern_gen.md
# cam_pattern_gen

Parametrised DVP camera stimulus source for the cam2vga testbench: it emits 8-bit byte-serial RGB565 frames with `cmos_vsyn`/`cmos_href` framing, clocked by the camera pixel clock. It feeds the DUT capture path as the synthetic camera. Compared with the fixed single-pattern generator it adds:
- runtime-selectable test patterns, latched per frame;
- selectable byte order;
- start/stop control with clean frame completion;
- a frame counter and end-of-frame strobe for scoreboard alignment.

## Interface
- `H_ACTIVE`, 800: pixels per line; must be a multiple of 16.
- `V_ACTIVE`, 480: active lines per frame.
- `H_BLANK`, 100: href-low cycles before each line's active bytes.
- `V_SYNC`, 1000: cycles `cmos_vsyn` is high per frame.
- `V_BACK`, 1000: cycles after vsync falls before the first line.
- `F_GAP`, 2000: idle cycles after the last line before the frame ends.
- `CHK_SHIFT`, 3: checkerboard square size is 2^CHK_SHIFT pixels/lines.

Ports:
- `cmos_pclk` in 1: clock; all logic runs on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: run request.
- `mode` in 2: pattern select.
- `byte_swap` in 1: 0 = high byte first, 1 = low byte first.
- `cmos_data` out 8: pixel byte.
- `cmos_href` out 1: line valid.
- `cmos_vsyn` out 1: frame sync, active high.
- `frame_cnt` out 16: completed frames.
- `frame_done` out 1: one-cycle strobe at frame end.

## Operation
- The FSM has states IDLE, VSYNC, VBACK, HBLANK, ACTIVE, FGAP. All outputs are registered.
- IDLE → VSYNC on the cycle `enable`=1 is sampled. `mode` and `byte_swap` are latched on this transition and held for the whole frame.
- VSYNC lasts V_SYNC cycles with `cmos_vsyn`=1, then → VBACK.
- VBACK lasts V_BACK cycles, then → HBLANK with row=0.
- HBLANK lasts H_BLANK cycles, then → ACTIVE.
- ACTIVE lasts 2·H_ACTIVE cycles with `cmos_href`=1.
  - Byte 2p carries pixel p's first byte; byte 2p+1 carries its second byte.
  - At the end of ACTIVE: if row < V_ACTIVE−1, row increments and → HBLANK; otherwise → FGAP.
- FGAP lasts F_GAP cycles.
  - On its last cycle `frame_done`=1 and `frame_cnt` increments, wrapping from 0xFFFF to 0.
  - Next state is VSYNC if `enable`=1 on that cycle, else IDLE. Back-to-back frames have no idle cycle.
- Deasserting `enable` mid-frame never truncates the frame; the current frame always completes.
- The 16-bit pixel value P(p,r) is a function of pixel p (0..H_ACTIVE−1), row r and the latched mode:
  - mode 0, sequence: a 16-bit counter cleared at VSYNC entry and incremented after each pixel; it wraps and continues across lines.
  - mode 1, colour bars: bar b = p / (H_ACTIVE/16), and P = 16'h8000 >> b.
  - mode 2, checkerboard: P = 16'hFFFF if p[CHK_SHIFT]^r[CHK_SHIFT], else 16'h0000.
  - mode 3, row ramp: P = r[15:0].
- Byte order: with `byte_swap`=0 the first byte is P[15:8] and the second is P[7:0]; with `byte_swap`=1 the order is reversed.
- Whenever `cmos_href`=0, `cmos_data` = 8'h00.

## Timing
- Reset values: `cmos_data`=0, `cmos_href`=0, `cmos_vsyn`=0, `frame_cnt`=0, `frame_done`=0, state IDLE, row and pixel counters 0.
- Reset wins over every other event and aborts any frame in progress immediately. The next edge with `rst_n`=1 behaves as IDLE.
- Start latency: `enable` is sampled high at edge k; `cmos_vsyn` is high after edge k+1.
- Frame period: V_SYNC + V_BACK + V_ACTIVE·(H_BLANK + 2·H_ACTIVE) + F_GAP cycles. With defaults this is 820000 cycles.
- `cmos_vsyn` and `cmos_href` are never high in the same cycle.
- `cmos_href` is high for exactly 2·H_ACTIVE consecutive cycles per line, exactly V_ACTIVE times per frame.
- `mode` and `byte_swap` changes take effect only at the next VSYNC entry.

## Test plan
Benches use H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, V_SYNC=8, V_BACK=4, F_GAP=4, CHK_SHIFT=1. This gives a 36-cycle line and a 160-cycle frame.
- Reset/idle: hold `rst_n`=0 for 5 cycles, then release with `enable`=0 → all outputs stay 0 and `frame_cnt`=0 indefinitely.
- Framing, mode 0: pulse `enable` for 1 cycle →
  - `cmos_vsyn` is high for 8 cycles;
  - the first `cmos_href` rises 4+4 cycles after vsync falls;
  - there are 4 href bursts of 32 cycles each;
  - bytes run 00,00,00,01,…,00,0F on line 0 and continue 00,10 on line 1;
  - `frame_done` pulses at cycle 160, `frame_cnt`=1, and the block returns to IDLE.
- Colour bars with swap: mode=1, `byte_swap`=1 → pixel 0 bytes are 00,80; pixel 15 bytes are 01,00.
- Checkerboard: mode=2 → row 0, pixel 2 is FF,FF; row 2, pixel 2 is 00,00.
- Mid-frame changes: hold `enable`=1 and switch mode 3→0 during row 1 →
  - the frame in progress stays a row ramp (row 1 bytes 00,01);
  - the next frame starts immediately after `frame_done` as a sequence;
  - deasserting `enable` during a frame lets that frame complete.
- Reset mid-line: assert `rst_n`=0 during ACTIVE → on the next edge `cmos_href`=0 and `cmos_data`=0, while `frame_cnt` and all internal counters clear.
- Wrap: force `frame_cnt`=16'hFFFF before a frame ends → it reads 0 after `frame_done`.
